line_buffer_3row: RTL and testbench
===================================

Name: line_buffer_3row

Overview:
- Upstream neighbour of the 3x3 Prewitt window stage. Converts a raster pixel stream into three vertically aligned row taps: din1 is the oldest row (r-2), din2 is row r-1, din3 is the current row r.
- Holds two full image lines in on-chip delay lines. Asserts valid_out only once two complete lines are buffered.
- Frame alignment comes from a start-of-frame pulse.

Parameters:
- WIDTH, 24: pixel width in bits. Gray value in [7:0], replicated x3.
- PIC_WIDTH, 320: pixels per line. Maximum 511.
- PIC_HEIGHT, 240: lines per frame. Maximum 511.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sof_in  in  1  start of frame. Qualified by valid_in and marks the pixel at row 0, col 0.
- valid_in  in  1  pix_in valid this cycle.
- pix_in  in  WIDTH  input pixel.
- valid_out  out  1  row taps valid.
- dout1  out  WIDTH  pixel from row r-2, same column.
- dout2  out  WIDTH  pixel from row r-1, same column.
- dout3  out  WIDTH  pixel from row r (delayed pix_in).
- col_out  out  9  column index of the current tap set.
- eol_out  out  1  high with the last column of each output row.

Behaviour:
- Reset (clk edge with rst=1):
  - All outputs are 0. The FSM goes to IDLE. col_cnt and row_cnt are 0.
  - Delay-line RAM contents are not cleared.
- Counters:
  - col_cnt increments on accepted pixels and wraps PIC_WIDTH-1 -> 0.
  - row_cnt increments on each col wrap.
  - An accepted pixel means valid_in=1 and FSM != IDLE, or sof_in.
- Delay lines (2 x PIC_WIDTH x WIDTH, single clock). On an accepted pixel at col c:
  - q1 <= mem1[c]; mem1[c] <= pix_in.
  - q2 <= mem2[c]; mem2[c] <= mem1[c] (old value).
  - Read-before-write, with a registered read.
- Output registers update on accepted pixels only:
  - dout3 <= pix_in; dout2 <= mem1[c]; dout1 <= mem2[c].
  - col_out <= c.
  - valid_out <= (state==RUN at this pixel).
  - eol_out <= (c==PIC_WIDTH-1) && RUN.
  - On cycles with no accepted pixel: valid_out=0 and eol_out=0. Data outputs hold.
- Latency: 1 clk from accepted pixel to taps.
- FSM states and transitions:
  - IDLE: ignores valid_in without sof_in. Goes to FILL on valid_in && sof_in.
  - FILL: row_cnt is 0 or 1. Goes to RUN when the first pixel of row 2 is accepted; that pixel itself is output with valid_out=1.
  - RUN: goes to IDLE after accepting row PIC_HEIGHT-1, col PIC_WIDTH-1. That pixel still produces valid_out=1.
- sof_in with valid_in in any state:
  - Restarts the frame: col=0, row=0, state FILL.
  - The pixel is stored as row 0 col 0. No valid_out for it.
- Gaps: valid_in=0 stalls everything. There are no timeouts.
- rst=1 mid-frame aborts the frame. Data is not resumed until the next sof_in.
- Edge columns are not padded. Column handling (cnt>2) is the window stage's job; col_out is provided for it.

Decomposition:
- Shared package holds:
  - default PIC_WIDTH/PIC_HEIGHT/WIDTH;
  - the counter width constant (9);
  - the FSM state encoding: IDLE=2'd0, FILL=2'd1, RUN=2'd2.
- One sub-module, line_delay_ram: parameters DEPTH and WIDTH. It has an address, write enable, write data, and registered read data with read-before-write. It is instantiated twice.

Test Plan:
- Test parameters: PIC_WIDTH=4, PIC_HEIGHT=4, pix_in = row*16+col (zero-extended).
1. Reset, then a full frame with continuous valid_in and sof_in on the first pixel:
   - No valid_out for rows 0-1.
   - Row 2 col 1 -> dout1=0x01, dout2=0x11, dout3=0x21, col_out=1.
   - 8 valid_out pulses in total.
2. Row 3 col 3 -> dout1=0x13, dout2=0x23, dout3=0x33, eol_out=1. State is IDLE on the next cycle.
3. Random valid_in gaps (~50%) over a frame:
   - Identical tap values/order to test 1.
   - valid_out never high on a gap cycle.
4. valid_in without sof_in after reset -> no output.
   - A following sof_in frame behaves as in test 1.
5. sof_in mid-row 2 of frame A:
   - valid_out drops to 0 for 8 accepted pixels.
   - The new frame's row 2 col 0 tap has dout3=0x20.
6. rst pulse during row 3:
   - Next cycle all outputs are 0 and the state is IDLE.
   - The next frame passes test 1.

Source files
------------

// File: rtl/line_buffer_3row_pkg.sv
// Shared constants, FSM encoding and counter helper for the three-row line buffer.
package line_buffer_3row_pkg;

   localparam int DEF_WIDTH      = 24;
   localparam int DEF_PIC_WIDTH  = 320;
   localparam int DEF_PIC_HEIGHT = 240;
   localparam int CNT_W          = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Increment with wrap at lim-1; used for the column counter.
   function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] last);
      return (v == last) ? '0 : v + 1'b1;
   endfunction

endpackage

// File: rtl/line_buffer_3row_delay_ram.sv
// One image line of delay storage: read-before-write with a registered read port,
// plus the pre-write contents at the address for cascading into the next line.
module line_delay_ram #(
   parameter int DEPTH = 320,
   parameter int WIDTH = 24,
   parameter int AW    = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [WIDTH-1:0] rd_now
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0] rdata_d;

   always_comb begin
      rd_now  = mem[addr];
      rdata_d = we ? rd_now : rdata_q;
   end

   // Storage is never cleared; only the read register follows reset.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/line_buffer_3row.sv
// Raster stream to three vertically aligned row taps (r-2, r-1, r) for a 3x3 window,
// framed by a start-of-frame pulse; taps are valid once two full lines are stored.
module line_buffer_3row
   import line_buffer_3row_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
   parameter int PIC_HEIGHT = DEF_PIC_HEIGHT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sof_in,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] pix_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] dout1,
   output logic [WIDTH-1:0] dout2,
   output logic [WIDTH-1:0] dout3,
   output logic [CNT_W-1:0] col_out,
   output logic             eol_out
);

   localparam int AW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(PIC_WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(PIC_HEIGHT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
   logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
   logic             valid_out_q, valid_out_d;
   logic             eol_out_q, eol_out_d;
   logic [WIDTH-1:0] dout3_q, dout3_d;
   logic [CNT_W-1:0] col_out_q, col_out_d;

   logic             acc;
   logic             run_now;
   logic [CNT_W-1:0] cur_col;
   logic [CNT_W-1:0] cur_row;
   logic [AW-1:0]    ram_addr;
   logic [WIDTH-1:0] mem1_old;
   logic [WIDTH-1:0] mem1_rd;
   logic [WIDTH-1:0] mem2_rd;
   logic [WIDTH-1:0] unused_mem2_old;

   always_comb begin
      acc      = valid_in && ((state_q != ST_IDLE) || sof_in);
      // A qualified sof restarts at row 0 col 0 regardless of where the counters are.
      cur_col  = sof_in ? '0 : col_cnt_q;
      cur_row  = sof_in ? '0 : row_cnt_q;
      run_now  = !sof_in && ((state_q == ST_RUN) ||
                             ((state_q == ST_FILL) && (row_cnt_q == CNT_W'(2))));
      ram_addr = cur_col[AW-1:0];

      state_d     = state_q;
      col_cnt_d   = col_cnt_q;
      row_cnt_d   = row_cnt_q;
      valid_out_d = 1'b0;
      eol_out_d   = 1'b0;
      dout3_d     = dout3_q;
      col_out_d   = col_out_q;

      if (acc) begin
         dout3_d     = pix_in;
         col_out_d   = cur_col;
         valid_out_d = run_now;
         eol_out_d   = run_now && (cur_col == LAST_COL);
         col_cnt_d   = wrap_inc(cur_col, LAST_COL);
         row_cnt_d   = (cur_col == LAST_COL) ? cur_row + 1'b1 : cur_row;

         if (sof_in) begin
            state_d = ST_FILL;
         end else if (run_now) begin
            if ((cur_row == LAST_ROW) && (cur_col == LAST_COL)) begin
               state_d   = ST_IDLE;
               row_cnt_d = '0;
            end else begin
               state_d = ST_RUN;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         col_cnt_q   <= '0;
         row_cnt_q   <= '0;
         valid_out_q <= 1'b0;
         eol_out_q   <= 1'b0;
         dout3_q     <= '0;
         col_out_q   <= '0;
      end else begin
         state_q     <= state_d;
         col_cnt_q   <= col_cnt_d;
         row_cnt_q   <= row_cnt_d;
         valid_out_q <= valid_out_d;
         eol_out_q   <= eol_out_d;
         dout3_q     <= dout3_d;
         col_out_q   <= col_out_d;
      end
   end

   // Line 1 holds row r-1; its pre-write word shifts into line 2 (row r-2).
   line_delay_ram #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH), .AW(AW)) u_line1 (
      .clk    (clk),
      .rst    (rst),
      .we     (acc),
      .addr   (ram_addr),
      .wdata  (pix_in),
      .rdata  (mem1_rd),
      .rd_now (mem1_old)
   );

   line_delay_ram #(.DEPTH(PIC_WIDTH), .WIDTH(WIDTH), .AW(AW)) u_line2 (
      .clk    (clk),
      .rst    (rst),
      .we     (acc),
      .addr   (ram_addr),
      .wdata  (mem1_old),
      .rdata  (mem2_rd),
      .rd_now (unused_mem2_old)
   );

   assign valid_out = valid_out_q;
   assign eol_out   = eol_out_q;
   assign dout3     = dout3_q;
   assign dout2     = mem1_rd;
   assign dout1     = mem2_rd;
   assign col_out   = col_out_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Scoreboard bench for line_buffer_3row on a 4x4 picture with pixel = row*16+col.
module tb_line_buffer_3row;
   import line_buffer_3row_pkg::*;

   localparam int W  = 24;
   localparam int PW = 4;
   localparam int PH = 4;

   typedef struct packed {
      logic [W-1:0] d1;
      logic [W-1:0] d2;
      logic [W-1:0] d3;
      logic [8:0]   col;
      logic         eol;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sof_in = 1'b0;
   logic         valid_in = 1'b0;
   logic [W-1:0] pix_in = '0;
   logic         valid_out;
   logic [W-1:0] dout1, dout2, dout3;
   logic [8:0]   col_out;
   logic         eol_out;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   vld_cnt = 0;
   bit   in_frame = 1'b0;

   line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
      .clk       (clk),
      .rst       (rst),
      .sof_in    (sof_in),
      .valid_in  (valid_in),
      .pix_in    (pix_in),
      .valid_out (valid_out),
      .dout1     (dout1),
      .dout2     (dout2),
      .dout3     (dout3),
      .col_out   (col_out),
      .eol_out   (eol_out)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] pv(input int r, input int c);
      return W'(r * 16 + c);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: taps appear exactly one clock after each accepted pixel.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (valid_out) begin
            vld_cnt++;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_valid: got col=%0d d1=%0h d2=%0h d3=%0h, no tap expected",
                        col_out, dout1, dout2, dout3);
            end else begin
               e = exp_q.pop_front();
               if ({dout1, dout2, dout3, col_out, eol_out} !== e) begin
                  n_fail++;
                  $display("FAIL tap: got d1=%0h d2=%0h d3=%0h col=%0d eol=%0b expected d1=%0h d2=%0h d3=%0h col=%0d eol=%0b",
                           dout1, dout2, dout3, col_out, eol_out, e.d1, e.d2, e.d3, e.col, e.eol);
               end
            end
         end else begin
            n_tests++;
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               n_fail++;
               $display("FAIL missing_valid: got valid_out=0 expected tap col=%0d d3=%0h", e.col, e.d3);
            end else if (eol_out) begin
               n_fail++;
               $display("FAIL stray_eol: got eol_out=1 expected 0 with valid_out=0");
            end
         end
      end
   end

   task automatic send(input bit sof, input int r, input int c);
      exp_t e;
      sof_in   = sof;
      valid_in = 1'b1;
      pix_in   = pv(r, c);
      if (sof) in_frame = 1'b1;
      @(posedge clk);
      if (in_frame && !sof && r >= 2) begin
         e.d1  = pv(r - 2, c);
         e.d2  = pv(r - 1, c);
         e.d3  = pv(r, c);
         e.col = 9'(c);
         e.eol = (c == PW - 1);
         exp_q.push_back(e);
      end
      if (r == PH - 1 && c == PW - 1) in_frame = 1'b0;
      #1;
      valid_in = 1'b0;
      sof_in   = 1'b0;
   endtask

   task automatic gap();
      valid_in = 1'b0;
      sof_in   = 1'($urandom_range(1, 0));
      pix_in   = W'($urandom);
      @(posedge clk);
      #1;
      sof_in = 1'b0;
   endtask

   task automatic send_cols(input int r, input int c0, input int c1, input bit gaps);
      for (int c = c0; c <= c1; c++) begin
         if (gaps && $urandom_range(1, 0) == 1) gap();
         send(r == 0 && c == 0, r, c);
      end
   endtask

   task automatic send_rows(input int r0, input int r1, input bit gaps);
      for (int r = r0; r <= r1; r++) send_cols(r, 0, PW - 1, gaps);
   endtask

   task automatic chk_zero_outputs(input string name);
      chk({name, "_valid"}, 32'(valid_out), 32'd0);
      chk({name, "_eol"},   32'(eol_out),   32'd0);
      chk({name, "_dout1"}, 32'(dout1),     32'd0);
      chk({name, "_dout2"}, 32'(dout2),     32'd0);
      chk({name, "_dout3"}, 32'(dout3),     32'd0);
      chk({name, "_col"},   32'(col_out),   32'd0);
      chk({name, "_state"}, 32'(dut.state_q), 32'(ST_IDLE));
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_zero_outputs("reset");

      // Full frame, continuous valid, with directed taps at row 2 col 1 and row 3 col 3
      vld_cnt = 0;
      send_rows(0, 1, 1'b0);
      send_cols(2, 0, 1, 1'b0);
      @(negedge clk);
      chk("r2c1_dout1", 32'(dout1), 32'h01);
      chk("r2c1_dout2", 32'(dout2), 32'h11);
      chk("r2c1_dout3", 32'(dout3), 32'h21);
      chk("r2c1_col",   32'(col_out), 32'd1);
      send_cols(2, 2, 3, 1'b0);
      send_cols(3, 0, 3, 1'b0);
      @(negedge clk);
      chk("r3c3_dout1", 32'(dout1), 32'h13);
      chk("r3c3_dout2", 32'(dout2), 32'h23);
      chk("r3c3_dout3", 32'(dout3), 32'h33);
      chk("r3c3_eol",   32'(eol_out), 32'd1);
      chk("end_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
      #1;
      chk("frame1_pulses", 32'(vld_cnt), 32'd8);

      // Same frame with random valid gaps
      vld_cnt = 0;
      send_rows(0, PH - 1, 1'b1);
      @(negedge clk);
      #1;
      chk("gap_frame_pulses", 32'(vld_cnt), 32'd8);

      // Pixels without sof after reset are ignored
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      vld_cnt = 0;
      for (int i = 0; i < 12; i++) send(1'b0, 2 + (i / 4) % 2, i % 4);
      @(negedge clk);
      #1;
      chk("nosof_pulses", 32'(vld_cnt), 32'd0);
      chk("nosof_state",  32'(dut.state_q), 32'(ST_IDLE));
      vld_cnt = 0;
      send_rows(0, PH - 1, 1'b0);
      @(negedge clk);
      #1;
      chk("after_nosof_pulses", 32'(vld_cnt), 32'd8);

      // sof mid row 2 of frame A restarts the frame
      send_rows(0, 1, 1'b0);
      send_cols(2, 0, 1, 1'b0);
      @(negedge clk);
      #1;
      vld_cnt = 0;
      send_rows(0, 1, 1'b0);
      @(negedge clk);
      #1;
      chk("restart_quiet_pulses", 32'(vld_cnt), 32'd0);
      send_cols(2, 0, 0, 1'b0);
      @(negedge clk);
      chk("restart_r2c0_dout3", 32'(dout3), 32'h20);
      chk("restart_r2c0_dout2", 32'(dout2), 32'h10);
      chk("restart_r2c0_dout1", 32'(dout1), 32'h00);
      send_cols(2, 1, 3, 1'b0);
      send_cols(3, 0, 3, 1'b0);
      @(negedge clk);
      #1;
      chk("restart_pulses", 32'(vld_cnt), 32'd8);

      // rst during row 3 aborts the frame
      send_rows(0, 2, 1'b0);
      send_cols(3, 0, 1, 1'b0);
      rst = 1'b1;
      in_frame = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_zero_outputs("midrst");
      vld_cnt = 0;
      send_rows(0, PH - 1, 1'b0);
      @(negedge clk);
      #1;
      chk("post_rst_pulses", 32'(vld_cnt), 32'd8);

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
